// File: rtl/serial_subtractor8_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The bit counter has to hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor8_full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow is raised when b exceeds a, or when they are equal and a borrow comes in.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor: Diff = A - B - Bin, LSB first, one bit per clock.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; Diff/Bout hold the last result
// SHIFT | one result bit produced per cycle, WIDTH cycles in total
// DONE  | done pulse cycle; a start here begins the next operation
module serial_subtractor8
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             d_bit_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  full_subtractor_bit u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (br_q),
    .d    (d_bit_d),
    .bout (br_d)
  );

  // New bit enters at the MSB so that after WIDTH shifts the LSB sits at bit 0.
  always_comb begin
    res_d = {d_bit_d, res_q[WIDTH-1:1]};
  end

  // Sequencing FSM with the shift datapath and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            br_q    <= Bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          res_q  <= res_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor8.sv
module tb_serial_subtractor8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic         busy, done, Bout;
  logic [W-1:0] Diff;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  serial_subtractor8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model: an accepted request yields A-B-Bin exactly WIDTH edges later.
  int         m_rem  = 0;
  bit         m_done = 1'b0;
  int         m_diff = 0;
  bit         m_bout = 1'b0;
  int         p_diff = 0;
  bit         p_bout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_done = 1'b0; m_diff = 0; m_bout = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_done = 1'b0;
      if (m_rem == 0) begin
        m_done = 1'b1; m_diff = p_diff; m_bout = p_bout;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        int ia, ib;
        ia = int'(A);
        ib = int'(B) + int'(Bin);
        p_diff = (ia - ib + 512) % 256;
        p_bout = (ia < ib);
        m_rem  = W;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
      check("model_done", {31'd0, done}, {31'd0, m_done});
      check("model_diff", {24'd0, Diff}, m_diff);
      check("model_bout", {31'd0, Bout}, {31'd0, m_bout});
    end
  end

  // Called at a negedge: presents a request for one edge, returns at the following negedge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    start = 1'b1; A = a; B = b; Bin = bi;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n0 = edges already elapsed counting the accept edge; done must appear after edge exp_n.
  task automatic wait_done(input int n0, input int exp_n, input string nm,
                           input logic [W-1:0] ed, input logic eb);
    int n;
    n = n0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, exp_n);
    check({nm, "_diff"}, {24'd0, Diff}, {24'd0, ed});
    check({nm, "_bout"}, {31'd0, Bout}, {31'd0, eb});
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic rbi;
    int ed;

    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_diff", {24'd0, Diff}, 0);
    check("rst_bout", {31'd0, Bout}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    launch(8'h69, 8'hDA, 1'b0);
    check("t1_busy", {31'd0, busy}, 1);
    wait_done(1, 9, "t1", 8'h8F, 1'b1);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, done}, 0);

    launch(8'hAF, 8'h39, 1'b1);
    wait_done(1, 9, "t2", 8'h75, 1'b0);
    @(negedge clk);
    launch(8'h00, 8'h00, 1'b1);
    wait_done(1, 9, "t3a", 8'hFF, 1'b1);
    @(negedge clk);
    launch(8'hFF, 8'hFF, 1'b0);
    check("t3b_hold_diff", {24'd0, Diff}, 32'hFF);
    wait_done(1, 9, "t3b", 8'h00, 1'b0);

    // second start during busy cycle 3, operand inputs also disturbed
    @(negedge clk);
    launch(8'h50, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    launch(8'h01, 8'hF0, 1'b1);
    A = 8'hAA; B = 8'h55; Bin = 1'b1;
    wait_done(4, 9, "t4", 8'h30, 1'b0);

    // reset in mid-operation
    @(negedge clk);
    launch(8'h33, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_done", {31'd0, done}, 0);
    check("t5_diff", {24'd0, Diff}, 0);
    check("t5_bout", {31'd0, Bout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("t5_no_done", seen, 0);
    launch(8'h33, 8'h11, 1'b0);
    wait_done(1, 9, "t5_after", 8'h22, 1'b0);

    // back-to-back: start presented in the DONE cycle
    launch(8'h10, 8'h01, 1'b0);
    check("t6_busy", {31'd0, busy}, 1);
    check("t6_done_drop", {31'd0, done}, 0);
    wait_done(1, 9, "t6", 8'h0F, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      ed = (int'(ra) - int'(rb) - int'(rbi)) & 255;
      if ((i % 3) == 0) @(negedge clk);
      launch(ra, rb, rbi);
      wait_done(1, 9, "rnd", W'(ed), (int'(ra) < int'(rb) + int'(rbi)));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
